// File: rtl/issue_pkg.sv
// issue_pkg: shared issue-stage types, widths and scoreboard states
package issue_pkg;
  localparam int PREG_NUM = 32;
  localparam int ALU_WAKE_NUM = 2;
  localparam int COMMIT_WIDTH = 2;
  localparam int DISPATCH_WIDTH = 2;
  localparam int PREG_W = $clog2(PREG_NUM);
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [5:0] rob_ptr_t;
  typedef struct packed {
    logic [4:0] id;
    preg_t      pid;
  } src_t;
  typedef struct packed {
    logic       valid;
    logic       forward_en;
    logic [4:0] id;
    preg_t      pid;
  } iq_src_t;
  typedef struct packed {
    src_t        src1;
    src_t        src2;
    rob_ptr_t    dst;
    preg_t       dst_pid;
    logic        dst_wen;
    logic [7:0]  ctl;
    logic [31:0] imm;
    logic [31:0] pc;
  } dispatch_entry_t;
  typedef struct packed {
    iq_src_t     src1;
    iq_src_t     src2;
    rob_ptr_t    dst;
    preg_t       dst_pid;
    logic        dst_wen;
    logic [7:0]  ctl;
    logic [31:0] imm;
    logic [31:0] pc;
  } iq_entry_t;
  typedef struct packed {
    logic      valid;
    iq_entry_t entry;
  } write_req_t;
  typedef struct packed {
    logic  valid;
    preg_t pid;
  } wake_req_t;
  typedef enum logic [1:0] {COMMITTED, PENDING, DONE} sb_state_t;
endpackage

// File: rtl/preg_scoreboard.sv
// preg_scoreboard: per-preg readiness state with two bypassed lookup ports
module preg_scoreboard
  import issue_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      set_en,
  input  preg_t     set_pid,
  input  wake_req_t wake [ALU_WAKE_NUM],
  input  wake_req_t retire [COMMIT_WIDTH],
  input  preg_t     q_pid [2],
  output logic      q_valid [2],
  output logic      q_fwd [2]
);
  sb_state_t st [PREG_NUM];
  sb_state_t q_st [2];
  logic [PREG_NUM-1:0] woke, ret;
  always_comb begin
    woke = '0;
    ret = '0;
    for (int w = 0; w < ALU_WAKE_NUM; w++) if (wake[w].valid) woke[wake[w].pid] = 1'b1;
    for (int r = 0; r < COMMIT_WIDTH; r++) if (retire[r].valid) ret[retire[r].pid] = 1'b1;
  end
  always_ff @(posedge clk)
    for (int i = 0; i < PREG_NUM; i++)
      if (reset || flush || i == 0) st[i] <= COMMITTED;
      else if (set_en && set_pid == PREG_W'(i)) st[i] <= PENDING;
      else if (ret[i]) st[i] <= COMMITTED;
      else if (woke[i] && st[i] == PENDING) st[i] <= DONE;
  // lookups see this cycle's retires and wakes; the issue queue misses them otherwise
  always_comb
    for (int p = 0; p < 2; p++) begin
      q_st[p] = (q_pid[p] == '0 || ret[q_pid[p]]) ? COMMITTED : woke[q_pid[p]] ? DONE : st[q_pid[p]];
      q_valid[p] = q_st[p] != PENDING;
      q_fwd[p] = q_st[p] != COMMITTED;
    end
endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: compacting in-order buffer feeding the ALU issue queue one entry per cycle
module alu_dispatch
  import issue_pkg::*;
#(
  parameter int DISPATCH_WIDTH = 2,
  parameter int FQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [DISPATCH_WIDTH-1:0] in_valid,
  input  dispatch_entry_t           in_entry [DISPATCH_WIDTH],
  output logic                      in_ready,
  input  logic                      iq_full,
  input  logic                      stall,
  input  wake_req_t                 wake [ALU_WAKE_NUM],
  input  wake_req_t                 retire [COMMIT_WIDTH],
  output logic                      iq_wen,
  output write_req_t                iq_write
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  dispatch_entry_t fq [FQ_DEPTH];
  dispatch_entry_t hd;
  logic [CW-1:0] head, tail, count, pushes, acc;
  logic [AW-1:0] slot [DISPATCH_WIDTH];
  logic pop;
  preg_t q_pid [2];
  logic q_valid [2], q_fwd [2];
  assign in_ready = (CW'(FQ_DEPTH) - count >= CW'(DISPATCH_WIDTH)) && !flush;
  assign pop = count != '0 && !iq_full && !stall && !flush && !reset;
  assign hd = fq[head[AW-1:0]];
  assign q_pid[0] = hd.src1.pid;
  assign q_pid[1] = hd.src2.pid;
  always_comb begin
    pushes = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      slot[l] = tail[AW-1:0] + pushes[AW-1:0];
      pushes = pushes + CW'(in_valid[l]);
    end
    acc = in_ready ? pushes : '0;
  end
  always_ff @(posedge clk)
    if (in_ready && !reset)
      for (int l = 0; l < DISPATCH_WIDTH; l++) if (in_valid[l]) fq[slot[l]] <= in_entry[l];
  always_ff @(posedge clk)
    if (reset || flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + CW'(pop);
      tail <= tail + acc;
      count <= count + acc - CW'(pop);
    end
  preg_scoreboard u_sb (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .set_en(pop && hd.dst_wen && hd.dst_pid != '0),
    .set_pid(hd.dst_pid),
    .wake(wake),
    .retire(retire),
    .q_pid(q_pid),
    .q_valid(q_valid),
    .q_fwd(q_fwd)
  );
  always_comb begin
    iq_wen = pop;
    iq_write.valid = pop;
    iq_write.entry.src1 = '{valid: q_valid[0], forward_en: q_fwd[0], id: hd.src1.id, pid: hd.src1.pid};
    iq_write.entry.src2 = '{valid: q_valid[1], forward_en: q_fwd[1], id: hd.src2.id, pid: hd.src2.pid};
    iq_write.entry.dst = hd.dst;
    iq_write.entry.dst_pid = hd.dst_pid;
    iq_write.entry.dst_wen = hd.dst_wen;
    iq_write.entry.ctl = hd.ctl;
    iq_write.entry.imm = hd.imm;
    iq_write.entry.pc = hd.pc;
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed checks of buffering, pop control and scoreboard lookups
module tb_alu_dispatch;
  import issue_pkg::*;
  logic clk = 1'b0;
  logic reset, flush, iq_full, stall, in_ready, iq_wen, pu;
  logic [1:0] in_valid;
  dispatch_entry_t in_entry [2];
  wake_req_t wake [ALU_WAKE_NUM];
  wake_req_t retire [COMMIT_WIDTH];
  write_req_t iq_write;
  logic [31:0] q [$];
  int total = 0, bad = 0, cnt;
  always #5 clk = ~clk;
  alu_dispatch #(.DISPATCH_WIDTH(2), .FQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_entry(in_entry),
    .in_ready(in_ready), .iq_full(iq_full), .stall(stall), .wake(wake), .retire(retire),
    .iq_wen(iq_wen), .iq_write(iq_write)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic dispatch_entry_t mk(input logic [31:0] pc, input preg_t s1, input preg_t s2,
                                         input preg_t d, input logic wen);
    mk = '0;
    mk.pc = pc;
    mk.imm = ~pc;
    mk.src1 = '{id: s1, pid: s1};
    mk.src2 = '{id: s2, pid: s2};
    mk.dst_pid = d;
    mk.dst_wen = wen;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    #1;
    check({tag, ".wen"}, iq_wen, 0);
    check({tag, ".valid"}, iq_write.valid, 0);
  endtask
  task automatic pop_chk(input string tag, input logic [31:0] pc, input logic v1, input logic f1,
                         input logic v2, input logic f2);
    #1;
    check({tag, ".wen"}, iq_wen, 1);
    check({tag, ".valid"}, iq_write.valid, 1);
    check({tag, ".pc"}, iq_write.entry.pc, pc);
    check({tag, ".s1v"}, iq_write.entry.src1.valid, v1);
    check({tag, ".s1f"}, iq_write.entry.src1.forward_en, f1);
    check({tag, ".s2v"}, iq_write.entry.src2.valid, v2);
    check({tag, ".s2f"}, iq_write.entry.src2.forward_en, f2);
  endtask
  task automatic push1(input dispatch_entry_t e);
    in_valid = 2'b01;
    in_entry[0] = e;
    step;
    in_valid = 2'b00;
  endtask
  initial begin
    reset = 1; flush = 0; iq_full = 0; stall = 0; in_valid = 0;
    in_entry[0] = '0; in_entry[1] = '0;
    for (int i = 0; i < ALU_WAKE_NUM; i++) wake[i] = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) retire[i] = '0;
    step; step;
    reset = 0;
    #1 check("rst_rdy", in_ready, 1);
    idle_chk("rst");
    in_valid = 2'b11;
    in_entry[0] = mk(32'h10, 0, 3, 5, 1);
    in_entry[1] = mk(32'h14, 0, 3, 6, 1);
    idle_chk("latency");
    step;
    in_valid = 0;
    pop_chk("basic0", 32'h10, 1, 0, 1, 0);
    step;
    pop_chk("basic1", 32'h14, 1, 0, 1, 0);
    step;
    idle_chk("basic_empty");
    push1(mk(32'h20, 5, 0, 0, 0));
    pop_chk("dep", 32'h20, 0, 1, 1, 0);
    step;
    push1(mk(32'h24, 5, 0, 0, 0));
    wake[0] = '{valid: 1'b1, pid: 5'd5};
    pop_chk("wake_byp", 32'h24, 1, 1, 1, 0);
    step;
    wake[0] = '0;
    push1(mk(32'h28, 5, 0, 0, 0));
    pop_chk("done", 32'h28, 1, 1, 1, 0);
    step;
    push1(mk(32'h30, 0, 6, 0, 0));
    wake[1] = '{valid: 1'b1, pid: 5'd6};
    retire[0] = '{valid: 1'b1, pid: 5'd6};
    pop_chk("ret_prio", 32'h30, 1, 0, 1, 0);
    step;
    wake[1] = '0; retire[0] = '0;
    push1(mk(32'h34, 0, 6, 0, 0));
    pop_chk("committed", 32'h34, 1, 0, 1, 0);
    step;
    push1(mk(32'h38, 9, 9, 9, 1));
    pop_chk("own_dst", 32'h38, 1, 0, 1, 0);
    step;
    push1(mk(32'h3c, 9, 0, 0, 0));
    pop_chk("own_after", 32'h3c, 0, 1, 1, 0);
    step;
    iq_full = 1;
    in_valid = 2'b11;
    in_entry[0] = mk(32'h40, 0, 0, 0, 0);
    in_entry[1] = mk(32'h44, 0, 0, 0, 0);
    step;
    #1 check("half_rdy", in_ready, 1);
    in_entry[0] = mk(32'h48, 0, 0, 0, 0);
    in_entry[1] = mk(32'h4c, 0, 0, 0, 0);
    step;
    in_entry[0] = mk(32'h99, 0, 0, 0, 0);
    in_entry[1] = mk(32'h9c, 0, 0, 0, 0);
    #1 check("full_rdy", in_ready, 0);
    idle_chk("full");
    step;
    in_valid = 0;
    iq_full = 0;
    for (int i = 0; i < 4; i++) begin
      pop_chk("drain", 32'h40 + 32'(4 * i), 1, 0, 1, 0);
      step;
    end
    idle_chk("drain_empty");
    cnt = 0;
    for (int c = 0; c < 16; c++) begin
      pu = (c % 2) == 0;
      in_valid = pu ? 2'b11 : 2'b00;
      in_entry[0] = mk(32'h100 + 32'(8 * c), 0, 0, 0, 0);
      in_entry[1] = mk(32'h104 + 32'(8 * c), 0, 0, 0, 0);
      #1;
      check("wrap_rdy", in_ready, 32'(4 - cnt >= 2));
      check("wrap_wen", iq_wen, 32'(cnt != 0));
      if (cnt != 0) check("wrap_pc", iq_write.entry.pc, q[0]);
      if (cnt != 0) void'(q.pop_front());
      if (pu && 4 - cnt >= 2) begin
        q.push_back(32'h100 + 32'(8 * c));
        q.push_back(32'h104 + 32'(8 * c));
      end
      cnt = q.size();
      step;
    end
    in_valid = 0;
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      #1 check("wrap_tail", iq_write.entry.pc, q[0]);
      void'(q.pop_front());
      step;
    end
    idle_chk("wrap_empty");
    in_valid = 2'b11;
    in_entry[0] = mk(32'h60, 0, 0, 5, 1);
    in_entry[1] = mk(32'h64, 0, 0, 6, 1);
    step;
    in_valid = 0;
    pop_chk("pend5", 32'h60, 1, 0, 1, 0);
    step;
    pop_chk("pend6", 32'h64, 1, 0, 1, 0);
    step;
    iq_full = 1;
    in_valid = 2'b11;
    in_entry[0] = mk(32'h68, 0, 0, 0, 0);
    in_entry[1] = mk(32'h6c, 0, 0, 0, 0);
    step;
    push1(mk(32'h70, 0, 0, 0, 0));
    flush = 1;
    iq_full = 0;
    #1 check("flush_rdy", in_ready, 0);
    idle_chk("flush_cyc");
    step;
    flush = 0;
    #1 check("post_flush_rdy", in_ready, 1);
    idle_chk("post_flush");
    push1(mk(32'h74, 5, 6, 0, 0));
    pop_chk("flush_sb", 32'h74, 1, 0, 1, 0);
    step;
    idle_chk("flush_empty");
    in_valid = 2'b10;
    in_entry[0] = mk(32'h7c, 0, 0, 0, 0);
    in_entry[1] = mk(32'h80, 0, 0, 0, 0);
    step;
    in_valid = 2'b01;
    in_entry[0] = mk(32'h84, 0, 0, 0, 0);
    pop_chk("sparse0", 32'h80, 1, 0, 1, 0);
    step;
    in_valid = 0;
    pop_chk("sparse1", 32'h84, 1, 0, 1, 0);
    step;
    idle_chk("sparse_empty");
    push1(mk(32'h88, 0, 0, 0, 0));
    stall = 1;
    idle_chk("stall");
    step;
    stall = 0;
    pop_chk("unstall", 32'h88, 1, 0, 1, 0);
    step;
    iq_full = 1;
    in_valid = 2'b11;
    in_entry[0] = mk(32'h90, 0, 0, 0, 0);
    in_entry[1] = mk(32'h94, 0, 0, 0, 0);
    step;
    in_valid = 0;
    reset = 1;
    iq_full = 0;
    idle_chk("rst_mid");
    step;
    reset = 0;
    #1 check("rst_mid_rdy", in_ready, 1);
    idle_chk("rst_after");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Dispatch stage directly upstream of the ALU issue queue. Accepts up to DISPATCH_WIDTH renamed ALU micro-ops per cycle from rename into a small in-order buffer, then pops one per cycle into the issue queue's write port. The source ready (`valid`) and `forward_en` bits are computed at pop time from a per-physical-register scoreboard, so an entry never carries stale readiness. The scoreboard tracks wakeups and retirements.

## Interface
- DISPATCH_WIDTH, 2: rename lanes per cycle.
- FQ_DEPTH, 4: dispatch buffer entries; power of two, at least DISPATCH_WIDTH.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush.
- in_valid  in  DISPATCH_WIDTH  per-lane valid from rename.
- in_entry  in  DISPATCH_WIDTH x dispatch_entry_t  renamed micro-op: src1/src2 {id, pid}, dst (rob_ptr_t), dst_pid, dst_wen, ctl, imm, pc.
- in_ready  out  1  all valid lanes are accepted this cycle.
- iq_full  in  1  issue queue `full`.
- stall  in  1  backend stall; blocks pop.
- wake  in  ALU_WAKE_NUM x wake_req_t  execution wakeups.
- retire  in  COMMIT_WIDTH x wake_req_t  commit notifications.
- iq_wen  out  1  issue-queue write enable.
- iq_write  out  write_req_t  entry for the issue queue.

## Operation
- **Buffer.** Circular FIFO with head/tail pointers that carry an extra wrap bit, and a registered count.
  - in_ready = (FQ_DEPTH − count ≥ DISPATCH_WIDTH) && !flush. Same-cycle pops are not credited.
  - Push when in_ready: valid lanes are written in lane order to consecutive slots. Invalid lanes are skipped, so pushes are compacted.
- **Pop.** pop = (count ≠ 0) && !iq_full && !stall && !flush.
  - iq_wen = pop. iq_write.valid = pop.
  - iq_write.entry carries the head fields and sets src1.valid, src1.forward_en, src2.valid and src2.forward_en from the scoreboard.
  - count_next = count + pushes − pop.
- **Scoreboard.** One state per preg, sb_state_t:
  - COMMITTED: ready, forward_en = 0.
  - PENDING: not ready, forward_en = 1.
  - DONE: ready, forward_en = 1.
- **Scoreboard transitions** (per preg, highest priority first):
  - Popped entry with dst_wen and dst_pid ≠ 0 → PENDING.
  - Any matching valid retire → COMMITTED.
  - Matching valid wake while in PENDING → DONE. Wake in any other state is ignored.
  - Otherwise hold.
- **Preg 0** is hard-wired COMMITTED.
- **Source lookup.** Uses the current state with same-cycle bypass:
  - A matching retire this cycle reads as COMMITTED.
  - Else a matching wake this cycle reads as DONE.
  - Else the stored state is used.
  - The issue queue only observes wakes after its write, so this bypass is mandatory.
- **Own-dst hazard.** A source equal to the popped entry's own dst_pid uses the pre-update state.
- **Flush.**
  - Empties the buffer: head = tail, count = 0.
  - Returns every scoreboard entry to COMMITTED.
  - Suppresses push and pop that cycle.
  - Wins over all other events.

## Timing
- **Reset values:** buffer empty, all pregs COMMITTED, iq_wen = 0, iq_write.valid = 0, in_ready = 1.
- **Latency:** an entry pushed in cycle N can pop no earlier than N+1.
- **Outputs:** iq_wen and iq_write are combinational from the head entry, scoreboard state and the wake/retire inputs. The issue queue registers them.
- **Throughput:** at most one pop per cycle. Back-to-back pops see the previous pop's PENDING update, since state is registered.
- **Full buffer:** in_ready = 0; rename must hold its lanes.
- **Empty buffer:** iq_wen = 0 regardless of iq_full or stall.
- **Pointer wrap:** full vs empty is distinguished by the wrap bit, and count stays consistent.
- **Reset mid-stream:** buffer contents are dropped with no pop that cycle. Identical to flush plus full state reinit.

## Structure
- issue_pkg gains:
  - dispatch_entry_t;
  - sb_state_t, enum {COMMITTED, PENDING, DONE};
  - DISPATCH_WIDTH.
- write_req_t, wake_req_t, ALU_WAKE_NUM, COMMIT_WIDTH and PREG_NUM are reused from the existing packages.
- One sub-module, `preg_scoreboard`. It holds the state array and update priority logic and has two combinational bypassed lookup ports. alu_dispatch holds the FIFO, pop control and entry packing.

## Test plan
- **Basic lookup.** After reset, push two lanes (dst_pid 5 and 6, sources pid 0/3) → pop on consecutive cycles N+1 and N+2 with src valid = 1, forward_en = 0; pregs 5 and 6 become PENDING.
- **Dependency and wake bypass.** Pop an entry with src1.pid = 5 while 5 is PENDING → src1.valid = 0, forward_en = 1. Repeat with wake{5} in the pop cycle → src1.valid = 1, forward_en = 1.
- **Retire priority.** Pop with src2.pid = 6 while a wake and a retire for preg 6 arrive in the same cycle → src2.valid = 1, forward_en = 0; preg 6 becomes COMMITTED.
- **Backpressure and wrap.** Hold iq_full = 1 and push until count = 4 → in_ready = 0 and iq_wen = 0. Release → 4 pops in order, then continue pushing through several pointer wraps with ordering preserved.
- **Flush.** Flush with 3 entries queued and pregs 5/6 PENDING → next cycle count = 0, in_ready = 1, iq_wen = 0, and lookups of pregs 5/6 return valid = 1, forward_en = 0.
- **Sparse lanes.** Push with only in_valid[1] = 1 → exactly one entry is enqueued and it pops in order.
